// File: rtl/mem_arb.sv
// ============================================================================
// Module   : mem_arb
// Brief    : Two-requester (fetch/data) arbiter onto a single memory port with
//            one outstanding transaction and anti-starvation for fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,
    input  logic            d_req_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int              c_SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);
    localparam logic [c_SW-1:0] c_STARVE_ONE = c_SW'(1);
    localparam logic            c_OWN_FETCH  = 1'b0;
    localparam logic            c_OWN_DATA   = 1'b1;
    localparam logic [2:0]      c_SIZE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic [XLEN-1:0] r_adr;
    logic            r_we;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_size;
    logic [c_SW-1:0] r_starve;

    logic w_any_req;
    logic w_fetch_win;
    logic w_gnt;
    logic w_done;

    assign w_any_req   = if_req_i | d_req_i;
    assign w_fetch_win = if_req_i & (~d_req_i | (r_starve == c_STARVE_MAX));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_gnt = mem_gnt_i;
                // A response arriving with the grant closes the whole transaction.
                w_done = mem_gnt_i & mem_rvalid_i;
                if (mem_gnt_i) begin
                    w_state_nxt = mem_rvalid_i ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_done = mem_rvalid_i;
                if (mem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= c_OWN_DATA;
            r_adr    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_size   <= 3'b000;
            r_starve <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any_req) begin
                if (w_fetch_win) begin
                    r_owner  <= c_OWN_FETCH;
                    r_adr    <= if_adr_i;
                    r_we     <= 1'b0;
                    r_wdata  <= '0;
                    r_size   <= c_SIZE_WORD;
                    r_starve <= '0;
                end else begin
                    r_owner <= c_OWN_DATA;
                    r_adr   <= d_adr_i;
                    r_we    <= d_we_i;
                    r_wdata <= d_wdata_i;
                    r_size  <= d_size_i;
                    if (if_req_i && r_starve != c_STARVE_MAX) begin
                        r_starve <= r_starve + c_STARVE_ONE;
                    end
                end
            end
        end
    end

    // Outputs are forced quiet while reset is high so a dropped access never leaks a pulse.
    assign mem_req_o   = ~reset & (r_state == S_REQ);
    assign mem_adr_o   = reset ? '0 : r_adr;
    assign mem_we_o    = ~reset & r_we;
    assign mem_wdata_o = reset ? '0 : r_wdata;
    assign mem_size_o  = reset ? 3'b000 : r_size;

    assign if_gnt_o    = ~reset & w_gnt  & (r_owner == c_OWN_FETCH);
    assign d_gnt_o     = ~reset & w_gnt  & (r_owner == c_OWN_DATA);
    assign if_rvalid_o = ~reset & w_done & (r_owner == c_OWN_FETCH);
    assign d_rvalid_o  = ~reset & w_done & (r_owner == c_OWN_DATA);

    assign d_rdata_o = mem_rdata_i;

    generate
        if (XLEN >= 32) begin : g_rdata_wide
            assign if_rdata_o = mem_rdata_i[31:0];
        end else begin : g_rdata_narrow
            assign if_rdata_o = {{(32 - XLEN){1'b0}}, mem_rdata_i};
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
// Module   : tb_mem_arb
// Brief    : Self-checking bench for mem_arb against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req_i;
    logic [31:0]     if_adr_i;
    logic            if_gnt_o, if_rvalid_o;
    logic [31:0]     if_rdata_o;
    logic            d_req_i;
    logic [31:0]     d_adr_i;
    logic            d_we_i;
    logic [31:0]     d_wdata_i;
    logic [2:0]      d_size_i;
    logic            d_gnt_o, d_rvalid_o;
    logic [31:0]     d_rdata_o;
    logic            mem_req_o;
    logic [31:0]     mem_adr_o;
    logic            mem_we_o;
    logic [31:0]     mem_wdata_o;
    logic [2:0]      mem_size_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [31:0]     mem_rdata_i;

    always #5 clk = ~clk;

    mem_arb #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
        .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: whether a transaction is open, whether memory has accepted it, and its content.
    bit          m_open;
    bit          m_accepted;
    bit          m_is_data;
    logic [31:0] m_adr, m_wdata;
    logic        m_we;
    logic [2:0]  m_size;
    int          m_lost;
    bit          g_ig, g_dg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output for the current inputs, then advances the model across one edge.
    task automatic cycle();
        bit e_req, e_done, fw;
        #2;
        e_req  = !reset && m_open && !m_accepted;
        e_done = !reset && m_open && mem_rvalid_i && (m_accepted || mem_gnt_i);
        g_ig   = e_req && mem_gnt_i && !m_is_data;
        g_dg   = e_req && mem_gnt_i && m_is_data;
        chk("mem_req", {63'd0, mem_req_o}, {63'd0, e_req});
        chk("if_gnt", {63'd0, if_gnt_o}, {63'd0, g_ig});
        chk("d_gnt", {63'd0, d_gnt_o}, {63'd0, g_dg});
        chk("if_rvalid", {63'd0, if_rvalid_o}, {63'd0, e_done && !m_is_data});
        chk("d_rvalid", {63'd0, d_rvalid_o}, {63'd0, e_done && m_is_data});
        chk("if_rdata", {32'd0, if_rdata_o}, {32'd0, mem_rdata_i});
        chk("d_rdata", {32'd0, d_rdata_o}, {32'd0, mem_rdata_i});
        if (e_req || reset) begin
            chk("mem_adr", {32'd0, mem_adr_o}, reset ? 64'd0 : {32'd0, m_adr});
            chk("mem_we", {63'd0, mem_we_o}, reset ? 64'd0 : {63'd0, m_we});
            chk("mem_wdata", {32'd0, mem_wdata_o}, reset ? 64'd0 : {32'd0, m_wdata});
            chk("mem_size", {61'd0, mem_size_o}, reset ? 64'd0 : {61'd0, m_size});
        end
        if (reset) begin
            m_open = 0; m_accepted = 0; m_lost = 0;
        end else if (!m_open) begin
            if (if_req_i || d_req_i) begin
                fw = if_req_i && (!d_req_i || m_lost >= STARVE_MAX);
                m_open = 1; m_accepted = 0; m_is_data = !fw;
                if (fw) begin
                    m_adr = if_adr_i; m_we = 0; m_wdata = 0; m_size = 3'b010; m_lost = 0;
                end else begin
                    m_adr = d_adr_i; m_we = d_we_i; m_wdata = d_wdata_i; m_size = d_size_i;
                    if (if_req_i && m_lost < STARVE_MAX) m_lost++;
                end
            end
        end else if (e_done) begin
            m_open = 0;
        end else if (g_ig || g_dg) begin
            m_accepted = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ngr;
        bit fifth_fetch, sixth_data, first4_data;
        reset = 1; if_req_i = 0; if_adr_i = 0; d_req_i = 0; d_adr_i = 0; d_we_i = 0;
        d_wdata_i = 0; d_size_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'hA5A5_5A5A;
        m_open = 0; m_accepted = 0; m_is_data = 1; m_lost = 0;
        m_adr = 0; m_we = 0; m_wdata = 0; m_size = 0;
        cycle(); cycle();
        reset = 0;

        // Single fetch
        if_req_i = 1; if_adr_i = 32'h100; cycle();
        mem_gnt_i = 1; #1;
        chk("fetch_mem_req", {63'd0, mem_req_o}, 64'd1);
        chk("fetch_adr", {32'd0, mem_adr_o}, 64'h100);
        cycle();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13; #1;
        chk("fetch_rvalid", {63'd0, if_rvalid_o}, 64'd1);
        chk("fetch_rdata", {32'd0, if_rdata_o}, 64'h13);
        cycle();
        mem_rvalid_i = 0; cycle();

        // Simultaneous fetch and store: store first
        if_req_i = 1; if_adr_i = 32'h200;
        d_req_i = 1; d_adr_i = 32'h2000; d_we_i = 1; d_wdata_i = 32'hDEADBEEF; d_size_i = 3'b010;
        cycle();
        mem_gnt_i = 1; #1;
        chk("store_first_we", {63'd0, mem_we_o}, 64'd1);
        chk("store_first_adr", {32'd0, mem_adr_o}, 64'h2000);
        cycle();
        d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();
        mem_rvalid_i = 0; cycle();
        mem_gnt_i = 1; #1;
        chk("fetch_second_adr", {32'd0, mem_adr_o}, 64'h200);
        chk("fetch_second_we", {63'd0, mem_we_o}, 64'd0);
        cycle();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();
        mem_rvalid_i = 0; cycle();

        // Starvation: both held high, memory answers with the grant
        ngr = 0; fifth_fetch = 0; sixth_data = 0; first4_data = 1;
        d_we_i = 0; d_adr_i = 32'h4000; if_adr_i = 32'h300;
        for (int i = 0; i < 12; i++) begin
            if_req_i = 1; d_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; #1;
            if (if_gnt_o || d_gnt_o) begin
                ngr++;
                if (ngr <= 4 && !d_gnt_o) first4_data = 0;
                if (ngr == 5) fifth_fetch = if_gnt_o;
                if (ngr == 6) sixth_data = d_gnt_o;
            end
            cycle();
        end
        chk("starve_grants", ngr, 64'd6);
        chk("starve_first4_data", {63'd0, first4_data}, 64'd1);
        chk("starve_fifth_fetch", {63'd0, fifth_fetch}, 64'd1);
        chk("starve_cleared", {63'd0, sixth_data}, 64'd1);
        if_req_i = 0; d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;

        // Grant and response together on a load
        d_req_i = 1; d_adr_i = 32'h3000; d_we_i = 0; d_size_i = 3'b101; cycle();
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0001; #1;
        chk("load_gnt", {63'd0, d_gnt_o}, 64'd1);
        chk("load_rvalid", {63'd0, d_rvalid_o}, 64'd1);
        cycle();
        d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; #1;
        chk("load_idle", {63'd0, mem_req_o}, 64'd0);
        cycle();

        // Reset while waiting for a response
        d_req_i = 1; cycle();
        mem_gnt_i = 1; cycle();
        d_req_i = 0; mem_gnt_i = 0; cycle();
        reset = 1; mem_rvalid_i = 1; cycle();
        reset = 0; #1;
        chk("rst_no_rvalid", {63'd0, d_rvalid_o}, 64'd0);
        chk("rst_no_req", {63'd0, mem_req_o}, 64'd0);
        cycle();
        mem_rvalid_i = 0; if_req_i = 1; if_adr_i = 32'h500; cycle();
        mem_gnt_i = 1; #1;
        chk("rst_new_gnt", {63'd0, if_gnt_o}, 64'd1);
        cycle();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();
        mem_rvalid_i = 0;

        // Long grant stall: payload must hold
        d_req_i = 1; d_adr_i = 32'h7777_0000; d_we_i = 1; d_wdata_i = 32'h1234_5678; cycle();
        for (int i = 0; i < 10; i++) cycle();
        mem_gnt_i = 1; cycle();
        d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();
        mem_rvalid_i = 0; cycle();

        // Randomized traffic
        g_ig = 0; g_dg = 0;
        for (int i = 0; i < 3000; i++) begin
            if (g_ig || !if_req_i) begin
                if_req_i = ($urandom_range(0, 2) != 0);
                if_adr_i = $urandom;
            end
            if (g_dg || !d_req_i) begin
                d_req_i   = ($urandom_range(0, 2) != 0);
                d_adr_i   = $urandom;
                d_we_i    = 1'($urandom);
                d_wdata_i = $urandom;
                d_size_i  = 3'($urandom);
            end
            mem_gnt_i    = 1'($urandom);
            mem_rvalid_i = ($urandom_range(0, 2) == 0);
            mem_rdata_i  = $urandom;
            reset        = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter STARVE_MAX, default 4, lost fetch arbitrations before fetch is forced to win.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_req_i  input  1  instruction fetch request.
REQ-006 if_adr_i  input  XLEN  fetch address.
REQ-007 if_gnt_o  output  1  fetch request accepted by memory.
REQ-008 if_rvalid_o  output  1  fetch response valid, one-cycle pulse.
REQ-009 if_rdata_o  output  32  fetched instruction.
REQ-010 d_req_i  input  1  data access request.
REQ-011 d_adr_i  input  XLEN  data address.
REQ-012 d_we_i  input  1  1 = store, 0 = load.
REQ-013 d_wdata_i  input  XLEN  store data.
REQ-014 d_size_i  input  3  access size/sign code, passed through unchanged.
REQ-015 d_gnt_o  output  1  data request accepted by memory.
REQ-016 d_rvalid_o  output  1  data response valid (load data or store ack), one-cycle pulse.
REQ-017 d_rdata_o  output  XLEN  load data.
REQ-018 mem_req_o / mem_adr_o / mem_we_o / mem_wdata_o / mem_size_o  output  1/XLEN/1/XLEN/3  shared memory request bus.
REQ-019 mem_gnt_i  input  1  memory accepts the current request.
REQ-020 mem_rvalid_i / mem_rdata_i  input  1/XLEN  memory response.

Function
REQ-021 FSM states: IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-022 IDLE: if any req_i high, latch winner (owner) and its payload into registers, go to REQ; else stay.
REQ-023 Priority: data wins over fetch, unless starve_cnt == STARVE_MAX and if_req_i high, in which case fetch wins.
REQ-024 starve_cnt: +1 (saturating at STARVE_MAX) on each IDLE arbitration where if_req_i is high and data wins; cleared when fetch wins.
REQ-025 Latency: request present in IDLE cycle N, mem_req_o high from cycle N+1.
REQ-026 REQ: mem_req_o = 1, mem_* driven from latched registers, stable until mem_gnt_i; on mem_gnt_i go to WAIT.
REQ-027 Owner gnt_o = mem_gnt_i AND state==REQ AND owner match, combinational; non-owner gnt_o = 0.
REQ-028 Fetch: mem_we_o = 0, mem_wdata_o = 0, mem_size_o = 3'b010 (word).
REQ-029 Requester holds req and payload stable until its gnt_o; arbiter samples payload only in IDLE.
REQ-030 WAIT: on mem_rvalid_i, owner rvalid_o = 1 same cycle, rdata_o = mem_rdata_i; next state IDLE.
REQ-031 mem_rvalid_i in the same cycle as mem_gnt_i (state REQ): grant and response both completed, rvalid_o pulsed, next state IDLE.
REQ-032 mem_rvalid_i in IDLE, or in REQ without mem_gnt_i: ignored, no rvalid_o.
REQ-033 if_rdata_o = mem_rdata_i[31:0], d_rdata_o = mem_rdata_i always; qualified only by rvalid_o.
REQ-034 Requests arriving in REQ/WAIT are not accepted; they are arbitrated in the next IDLE cycle.
REQ-035 Back-to-back: minimum 3 cycles per transaction (IDLE, REQ, WAIT), 2 when REQ-031 applies.

Reset
REQ-036 reset high: state = IDLE, starve_cnt = 0, owner = data, latched payload = 0; all outputs 0 except rdata_o (pass-through).
REQ-037 Reset mid-transaction drops the outstanding access without pulsing rvalid_o; responses after reset follow REQ-032.

Verification
REQ-038 Single fetch: if_req_i=1, if_adr_i=0x100; mem_gnt_i next cycle; mem_rvalid_i with 0x00000013 two cycles later -> mem_req_o in cycle 1, if_gnt_o in cycle 1, if_rvalid_o=1, if_rdata_o=0x13 in cycle 2.
REQ-039 Simultaneous fetch and store (d_adr_i=0x2000, d_wdata_i=0xDEADBEEF) -> store issued first with mem_we_o=1; fetch issued in the following IDLE.
REQ-040 if_req_i and d_req_i held high continuously -> after 4 data wins, 5th grant goes to fetch; starve_cnt returns to 0.
REQ-041 mem_gnt_i and mem_rvalid_i in the same cycle on load -> d_gnt_o and d_rvalid_o pulse together; FSM in IDLE next cycle.
REQ-042 reset asserted in WAIT, then mem_rvalid_i=1 -> no rvalid_o; mem_req_o=0; new request accepted normally.
REQ-043 mem_gnt_i held 0 for 10 cycles -> mem_adr_o, mem_we_o, mem_wdata_o stable throughout; no gnt_o.
